// File: rtl/sdram_burst_data_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sdram_burst_data_pkg                                       |
// | Description : Shared constants for the SDRAM burst data path: write and  |
// |               read FSM state encodings, counter-width helper and the     |
// |               burst-length legality check.                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package sdram_burst_data_pkg;

    // Write-path FSM encoding
    localparam logic [1:0] c_w_collect = 2'd0;
    localparam logic [1:0] c_w_req     = 2'd1;
    localparam logic [1:0] c_w_sd      = 2'd2;

    // Read-path FSM encoding
    localparam logic [1:0] c_r_idle    = 2'd0;
    localparam logic [1:0] c_r_req     = 2'd1;
    localparam logic [1:0] c_r_sd      = 2'd2;
    localparam logic [1:0] c_r_out     = 2'd3;

    // Counters must be able to hold the value BL itself (read overflow detect),
    // hence one bit more than the index width.
    function automatic int cnt_width(input int bl);
        return $clog2(bl) + 1;
    endfunction

    function automatic bit bl_is_legal(input int bl);
        return (bl == 1) || (bl == 2) || (bl == 4) || (bl == 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_burst_data_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sdram_burst_buf                                            |
// | Description : DEPTH x WIDTH register file, one synchronous write port and |
// |               one combinational read port. Contents are not reset.       |
// |   clk      in   clock                                                    |
// |   i_we     in   write enable                                             |
// |   i_waddr  in   write index (IW bits, out-of-range writes are ignored)   |
// |   i_wdata  in   write data                                               |
// |   i_raddr  in   read index (out-of-range reads return zero)              |
// |   o_rdata  out  read data                                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sdram_burst_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18,
    parameter int IW    = 3
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [IW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    localparam int c_aw   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_rows = 1 << c_aw;

    logic [WIDTH-1:0] r_mem [c_rows];

    always_ff @(posedge clk) begin
        if (i_we && (i_waddr < IW'(DEPTH))) begin
            r_mem[i_waddr[c_aw-1:0]] <= i_wdata;
        end
    end

    // Index counters may legitimately sit at DEPTH; return zero there.
    assign o_rdata = (i_raddr < IW'(DEPTH)) ? r_mem[i_raddr[c_aw-1:0]] : '0;

endmodule
`default_nettype wire

// File: rtl/sdram_burst_data.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sdram_burst_data                                           |
// | Description : Data-path adapter between user write/read beat streams and |
// |               the SDRAM command controller. Gathers up to BL write beats |
// |               (with byte masks), requests a write and replays the burst  |
// |               to DQ; captures BL read beats and streams them out.        |
// |   user write : wr_data/wr_mask/wr_addr/wr_last, wr_valid/wr_ready        |
// |   user read  : rd_addr, rd_avalid/rd_aready; rd_data/rd_last,            |
// |                rd_valid/rd_ready                                         |
// |   controller : sys_wraddr/sys_rdaddr, sdram_wr_req/ack, wr_data_valid,   |
// |                sdram_data_o/dqm_o, wr_done, sdram_rd_req/ack,            |
// |                sdram_data_i(_valid), rd_done                             |
// |   status     : err_ovf (sticky read overflow / stray read beat)          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sdram_burst_data
    import sdram_burst_data_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 22,
    parameter int BL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     wr_data,
    input  logic [DW/8-1:0]   wr_mask,
    input  logic [AW-1:0]     wr_addr,
    input  logic              wr_last,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [AW-1:0]     rd_addr,
    input  logic              rd_avalid,
    output logic              rd_aready,
    output logic [DW-1:0]     rd_data,
    output logic              rd_last,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [AW-1:0]     sys_wraddr,
    output logic [AW-1:0]     sys_rdaddr,
    output logic              sdram_wr_req,
    input  logic              sdram_wr_ack,
    input  logic              sdram_wr_data_valid,
    output logic [DW-1:0]     sdram_data_o,
    output logic [DW/8-1:0]   sdram_dqm_o,
    input  logic              sdram_wr_done,
    output logic              sdram_rd_req,
    input  logic              sdram_rd_ack,
    input  logic              sdram_data_i_valid,
    input  logic [DW-1:0]     sdram_data_i,
    input  logic              sdram_rd_done,
    output logic              err_ovf
);

    localparam int MW = DW / 8;
    localparam int CW = cnt_width(BL);
    localparam logic [CW-1:0] c_bl      = CW'(BL);
    localparam logic [CW-1:0] c_bl_last = CW'(BL - 1);

    generate
        if (!bl_is_legal(BL) || (DW % 8) != 0 || DW < 8) begin : g_param_check
            $error("sdram_burst_data: BL must be 1, 2, 4 or 8 and DW a multiple of 8");
        end
    endgenerate

    // ---------------------------------------------------------------- write path
    logic [1:0]       r_wstate, w_wstate_nxt;
    logic [CW-1:0]    r_wcnt;
    logic [CW-1:0]    r_wlen;   // beats actually gathered; later beats go out masked
    logic [CW-1:0]    r_ridx;
    logic             w_wbeat, w_wfinal;
    logic [DW+MW-1:0] w_wbuf_rd;

    assign w_wbeat  = wr_valid && (r_wstate == c_w_collect);
    assign w_wfinal = w_wbeat && (wr_last || (r_wcnt == c_bl_last));

    sdram_burst_buf #(.DEPTH(BL), .WIDTH(DW + MW), .IW(CW)) u_wbuf (
        .clk     (clk),
        .i_we    (w_wbeat),
        .i_waddr (r_wcnt),
        .i_wdata ({wr_mask, wr_data}),
        .i_raddr (r_ridx),
        .o_rdata (w_wbuf_rd)
    );

    always_comb begin
        w_wstate_nxt = r_wstate;
        wr_ready     = 1'b0;
        sdram_wr_req = 1'b0;
        sdram_data_o = '0;
        sdram_dqm_o  = '1;
        case (r_wstate)
            c_w_collect: begin
                wr_ready = 1'b1;
                if (w_wfinal) w_wstate_nxt = c_w_req;
            end
            c_w_req: begin
                sdram_wr_req = 1'b1;
                if (sdram_wr_ack) w_wstate_nxt = c_w_sd;
            end
            c_w_sd: begin
                sdram_data_o = w_wbuf_rd[DW-1:0];
                // Beats past the gathered length are padding: keep them masked.
                if (sdram_wr_data_valid && (r_ridx < r_wlen)) begin
                    sdram_dqm_o = w_wbuf_rd[DW +: MW];
                end
                if (sdram_wr_done) w_wstate_nxt = c_w_collect;
            end
            default: w_wstate_nxt = c_w_collect;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate   <= c_w_collect;
            r_wcnt     <= '0;
            r_wlen     <= '0;
            r_ridx     <= '0;
            sys_wraddr <= '0;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (w_wbeat) begin
                r_wcnt <= r_wcnt + 1'b1;
                if (r_wcnt == '0) sys_wraddr <= wr_addr;
            end
            if (w_wfinal) r_wlen <= r_wcnt + 1'b1;
            if (r_wstate == c_w_sd) begin
                if (!sdram_wr_data_valid) begin
                    r_ridx <= '0;
                end else if (r_ridx != c_bl) begin
                    r_ridx <= r_ridx + 1'b1;
                end
                if (sdram_wr_done) begin
                    r_wcnt <= '0;
                    r_ridx <= '0;
                end
            end
        end
    end

    // ----------------------------------------------------------------- read path
    logic [1:0]    r_rstate, w_rstate_nxt;
    logic [CW-1:0] r_scnt;
    logic [CW-1:0] r_ocnt;
    logic          r_err;
    logic          w_rcap, w_rstray, w_rlast_hit;
    logic [DW-1:0] w_rbuf_rd;

    assign w_rcap      = sdram_data_i_valid && (r_rstate == c_r_sd) && (r_scnt != c_bl);
    assign w_rstray    = sdram_data_i_valid && !w_rcap;
    assign w_rlast_hit = (r_ocnt == c_bl_last);
    assign err_ovf     = r_err;

    sdram_burst_buf #(.DEPTH(BL), .WIDTH(DW), .IW(CW)) u_rbuf (
        .clk     (clk),
        .i_we    (w_rcap),
        .i_waddr (r_scnt),
        .i_wdata (sdram_data_i),
        .i_raddr (r_ocnt),
        .o_rdata (w_rbuf_rd)
    );

    always_comb begin
        w_rstate_nxt = r_rstate;
        rd_aready    = 1'b0;
        sdram_rd_req = 1'b0;
        rd_valid     = 1'b0;
        rd_data      = '0;
        rd_last      = 1'b0;
        case (r_rstate)
            c_r_idle: begin
                rd_aready = 1'b1;
                if (rd_avalid) w_rstate_nxt = c_r_req;
            end
            c_r_req: begin
                sdram_rd_req = 1'b1;
                if (sdram_rd_ack) w_rstate_nxt = c_r_sd;
            end
            c_r_sd: begin
                if (sdram_rd_done) w_rstate_nxt = c_r_out;
            end
            c_r_out: begin
                rd_valid = 1'b1;
                rd_data  = w_rbuf_rd;
                rd_last  = w_rlast_hit;
                if (rd_ready && w_rlast_hit) w_rstate_nxt = c_r_idle;
            end
            default: w_rstate_nxt = c_r_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate   <= c_r_idle;
            r_scnt     <= '0;
            r_ocnt     <= '0;
            r_err      <= 1'b0;
            sys_rdaddr <= '0;
        end else begin
            r_rstate <= w_rstate_nxt;
            if ((r_rstate == c_r_idle) && rd_avalid) begin
                sys_rdaddr <= rd_addr;
                r_scnt     <= '0;
            end
            if (w_rcap) r_scnt <= r_scnt + 1'b1;
            // Either a beat past BL or a beat while no read is being captured.
            if (w_rstray) r_err <= 1'b1;
            if ((r_rstate == c_r_out) && rd_ready) begin
                r_ocnt <= w_rlast_hit ? '0 : r_ocnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_burst_data.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sdram_burst_data                                        |
// | Description : Self-checking bench for sdram_burst_data. Plays the user   |
// |               and controller sides, keeps the expected burst contents in |
// |               arrays/queues and compares DQ and read-stream outputs.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sdram_burst_data;

    localparam int DW = 16;
    localparam int AW = 22;
    localparam int BL = 4;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [MW-1:0] wr_mask = '0;
    logic [AW-1:0] wr_addr = '0;
    logic          wr_last = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_avalid = 1'b0;
    logic          rd_aready;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [AW-1:0] sys_wraddr;
    logic [AW-1:0] sys_rdaddr;
    logic          sdram_wr_req;
    logic          sdram_wr_ack = 1'b0;
    logic          sdram_wr_data_valid = 1'b0;
    logic [DW-1:0] sdram_data_o;
    logic [MW-1:0] sdram_dqm_o;
    logic          sdram_wr_done = 1'b0;
    logic          sdram_rd_req;
    logic          sdram_rd_ack = 1'b0;
    logic          sdram_data_i_valid = 1'b0;
    logic [DW-1:0] sdram_data_i = '0;
    logic          sdram_rd_done = 1'b0;
    logic          err_ovf;

    int n_vec = 0;
    int n_err = 0;
    bit exp_err = 1'b0;

    // Reference model: what the user handed over, and what DQ returned
    logic [DW-1:0] w_data_q [BL];
    logic [MW-1:0] w_mask_q [BL];
    int            w_n;
    logic [AW-1:0] w_addr_exp;
    logic [DW-1:0] r_exp [$];

    sdram_burst_data #(.DW(DW), .AW(AW), .BL(BL)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .wr_data             (wr_data),
        .wr_mask             (wr_mask),
        .wr_addr             (wr_addr),
        .wr_last             (wr_last),
        .wr_valid            (wr_valid),
        .wr_ready            (wr_ready),
        .rd_addr             (rd_addr),
        .rd_avalid           (rd_avalid),
        .rd_aready           (rd_aready),
        .rd_data             (rd_data),
        .rd_last             (rd_last),
        .rd_valid            (rd_valid),
        .rd_ready            (rd_ready),
        .sys_wraddr          (sys_wraddr),
        .sys_rdaddr          (sys_rdaddr),
        .sdram_wr_req        (sdram_wr_req),
        .sdram_wr_ack        (sdram_wr_ack),
        .sdram_wr_data_valid (sdram_wr_data_valid),
        .sdram_data_o        (sdram_data_o),
        .sdram_dqm_o         (sdram_dqm_o),
        .sdram_wr_done       (sdram_wr_done),
        .sdram_rd_req        (sdram_rd_req),
        .sdram_rd_ack        (sdram_rd_ack),
        .sdram_data_i_valid  (sdram_data_i_valid),
        .sdram_data_i        (sdram_data_i),
        .sdram_rd_done       (sdram_rd_done),
        .err_ovf             (err_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no summary, expected completion");
        $fatal(1, "simulation time limit");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset asserted from wherever the DUT is; outputs must drop to reset values at once.
    task automatic test_reset;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({wr_ready, rd_aready, sdram_dqm_o} !== {1'b1, 1'b1, {MW{1'b1}}}) begin
            n_err++;
            $display("FAIL reset_ones: got wr_ready=%b rd_aready=%b dqm=%b, expected 1 1 all-ones",
                     wr_ready, rd_aready, sdram_dqm_o);
        end
        n_vec++;
        if ({sdram_wr_req, sdram_rd_req, rd_valid, rd_last, err_ovf} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_zero: got wr_req=%b rd_req=%b rd_valid=%b rd_last=%b err=%b, expected all 0",
                     sdram_wr_req, sdram_rd_req, rd_valid, rd_last, err_ovf);
        end
        n_vec++;
        if (sys_wraddr !== '0 || sys_rdaddr !== '0 || sdram_data_o !== '0 || rd_data !== '0) begin
            n_err++;
            $display("FAIL reset_data: got wraddr=%h rdaddr=%h dq=%h rd_data=%h, expected 0",
                     sys_wraddr, sys_rdaddr, sdram_data_o, rd_data);
        end
        wr_valid = 1'b0; wr_last = 1'b0; rd_avalid = 1'b0; rd_ready = 1'b0;
        sdram_wr_ack = 1'b0; sdram_wr_data_valid = 1'b0; sdram_wr_done = 1'b0;
        sdram_rd_ack = 1'b0; sdram_data_i_valid = 1'b0; sdram_rd_done = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        exp_err = 1'b0;
        tick;
        n_vec++;
        if (wr_ready !== 1'b1 || rd_aready !== 1'b1 || err_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got wr_ready=%b rd_aready=%b err=%b, expected 1 1 0",
                     wr_ready, rd_aready, err_ovf);
        end
    endtask

    // User side: hand over n beats; fixed=1 uses the 0x1111.. pattern at 0x00100.
    task automatic wr_gather(input int n, input bit fixed);
        bit last;
        w_n = n;
        w_addr_exp = fixed ? AW'(22'h00100) : AW'($urandom);
        for (int i = 0; i < BL; i++) begin
            w_data_q[i] = fixed ? DW'((i + 1) * 'h1111) : DW'($urandom);
            w_mask_q[i] = fixed ? '0 : MW'($urandom);
        end
        for (int i = 0; i < n; i++) begin
            if (!fixed && i > 0 && $urandom_range(0, 2) == 0) begin
                wr_valid = 1'b0;
                tick;
            end
            n_vec++;
            if (wr_ready !== 1'b1) begin
                n_err++;
                $display("FAIL wr_ready_collect[%0d]: got %b, expected 1", i, wr_ready);
            end
            last = (i == n - 1) && ((n < BL) || (!fixed && $urandom_range(0, 1) == 1));
            wr_valid = 1'b1;
            wr_data  = w_data_q[i];
            wr_mask  = w_mask_q[i];
            wr_addr  = (i == 0) ? w_addr_exp : AW'($urandom);
            wr_last  = last;
            tick;
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        n_vec++;
        if (sdram_wr_req !== 1'b1 || wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL wr_req_latency: got wr_req=%b wr_ready=%b, expected 1 0", sdram_wr_req, wr_ready);
        end
        n_vec++;
        if (sys_wraddr !== w_addr_exp) begin
            n_err++;
            $display("FAIL sys_wraddr: got %h, expected %h", sys_wraddr, w_addr_exp);
        end
    endtask

    // Controller side: ack after a delay, pop BL beats, then signal write done.
    task automatic wr_burst(input int ack_delay);
        logic [MW-1:0] exp_m;
        for (int d = 0; d < ack_delay; d++) begin
            tick;
            n_vec++;
            if (sdram_wr_req !== 1'b1) begin
                n_err++;
                $display("FAIL wr_req_hold: got %b, expected 1", sdram_wr_req);
            end
        end
        sdram_wr_ack = 1'b1;
        tick;
        sdram_wr_ack = 1'b0;
        n_vec++;
        if (sdram_wr_req !== 1'b0 || wr_ready !== 1'b0 || sdram_dqm_o !== {MW{1'b1}}) begin
            n_err++;
            $display("FAIL wr_sd_enter: got wr_req=%b wr_ready=%b dqm=%b, expected 0 0 all-ones",
                     sdram_wr_req, wr_ready, sdram_dqm_o);
        end
        if ($urandom_range(0, 1) == 1) tick;
        for (int b = 0; b < BL; b++) begin
            sdram_wr_data_valid = 1'b1;
            #1;
            exp_m = (b < w_n) ? w_mask_q[b] : {MW{1'b1}};
            n_vec++;
            if (sdram_dqm_o !== exp_m) begin
                n_err++;
                $display("FAIL dqm[%0d]: got %b, expected %b", b, sdram_dqm_o, exp_m);
            end
            if (b < w_n) begin
                n_vec++;
                if (sdram_data_o !== w_data_q[b]) begin
                    n_err++;
                    $display("FAIL dq[%0d]: got %h, expected %h", b, sdram_data_o, w_data_q[b]);
                end
            end
            @(posedge clk);
            #1;
        end
        sdram_wr_data_valid = 1'b0;
        sdram_wr_done = 1'b1;
        tick;
        sdram_wr_done = 1'b0;
        n_vec++;
        if (wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL wr_done_ready: got %b, expected 1", wr_ready);
        end
    endtask

    task automatic rd_addr_phase(input logic [AW-1:0] a);
        int w = 0;
        while (rd_aready !== 1'b1 && w < 20) begin
            tick;
            w++;
        end
        n_vec++;
        if (rd_aready !== 1'b1) begin
            n_err++;
            $display("FAIL rd_aready_wait: got %b, expected 1 within 20 cycles", rd_aready);
        end
        rd_avalid = 1'b1;
        rd_addr   = a;
        tick;
        rd_avalid = 1'b0;
        n_vec++;
        if (rd_aready !== 1'b0 || sdram_rd_req !== 1'b1 || sys_rdaddr !== a) begin
            n_err++;
            $display("FAIL rd_req: got aready=%b rd_req=%b rdaddr=%h, expected 0 1 %h",
                     rd_aready, sdram_rd_req, sys_rdaddr, a);
        end
    endtask

    task automatic rd_ack(input int delay);
        for (int d = 0; d < delay; d++) tick;
        sdram_rd_ack = 1'b1;
        tick;
        sdram_rd_ack = 1'b0;
        n_vec++;
        if (sdram_rd_req !== 1'b0) begin
            n_err++;
            $display("FAIL rd_req_drop: got %b, expected 0", sdram_rd_req);
        end
    endtask

    // Controller delivers nb DQ beats then rd_done; only the first BL are expected out.
    task automatic rd_capture(input int nb);
        logic [DW-1:0] d;
        r_exp.delete();
        for (int k = 0; k < nb; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                sdram_data_i_valid = 1'b0;
                tick;
            end
            d = DW'($urandom);
            sdram_data_i = d;
            sdram_data_i_valid = 1'b1;
            if (k < BL) r_exp.push_back(d);
            else exp_err = 1'b1;
            tick;
        end
        sdram_data_i_valid = 1'b0;
        n_vec++;
        if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rd_valid_early: got %b, expected 0", rd_valid);
        end
        sdram_rd_done = 1'b1;
        tick;
        sdram_rd_done = 1'b0;
        n_vec++;
        if (rd_valid !== 1'b1 || err_ovf !== exp_err) begin
            n_err++;
            $display("FAIL rd_done_latency: got rd_valid=%b err=%b, expected 1 %b", rd_valid, err_ovf, exp_err);
        end
    endtask

    // User side drains BL beats; toggle=1 alternates rd_ready, else random stalls.
    task automatic rd_drain(input bit toggle);
        int k = 0;
        int cyc = 0;
        while (k < BL && cyc < 64) begin
            rd_ready = toggle ? ((cyc % 2) == 1) : ($urandom_range(0, 1) == 1);
            n_vec++;
            if (rd_valid !== 1'b1 || rd_data !== r_exp[k] || rd_last !== (k == BL - 1)) begin
                n_err++;
                $display("FAIL rd_beat[%0d]: got valid=%b data=%h last=%b, expected 1 %h %b",
                         k, rd_valid, rd_data, rd_last, r_exp[k], (k == BL - 1));
            end
            if (rd_ready) k++;
            tick;
            cyc++;
        end
        rd_ready = 1'b0;
        if (k < BL) begin
            n_vec++;
            n_err++;
            $display("FAIL rd_drain_timeout: got %0d beats, expected %0d", k, BL);
        end
        n_vec++;
        if (rd_valid !== 1'b0 || rd_aready !== 1'b1) begin
            n_err++;
            $display("FAIL rd_end: got rd_valid=%b aready=%b, expected 0 1", rd_valid, rd_aready);
        end
    endtask

    task automatic test_full_write;
        wr_gather(BL, 1'b1);
        wr_burst(2);
    endtask

    task automatic test_short_write;
        wr_gather(2, 1'b1);
        wr_burst(0);
    endtask

    task automatic test_random_writes;
        for (int t = 0; t < 8; t++) begin
            wr_gather($urandom_range(1, BL), 1'b0);
            wr_burst($urandom_range(0, 3));
        end
    endtask

    task automatic test_read_stall;
        rd_addr_phase(AW'(22'h00200));
        rd_ack(1);
        rd_capture(BL);
        rd_drain(1'b1);
    endtask

    task automatic test_random_reads;
        for (int t = 0; t < 6; t++) begin
            rd_addr_phase(AW'($urandom));
            rd_ack($urandom_range(0, 3));
            rd_capture(BL);
            rd_drain(1'b0);
        end
    endtask

    task automatic test_concurrent;
        wr_gather(BL, 1'b0);
        rd_addr_phase(AW'($urandom));
        n_vec++;
        if (sdram_wr_req !== 1'b1 || sdram_rd_req !== 1'b1) begin
            n_err++;
            $display("FAIL both_req: got wr_req=%b rd_req=%b, expected 1 1", sdram_wr_req, sdram_rd_req);
        end
        rd_ack(0);
        rd_capture(BL);
        wr_burst(0);
        rd_drain(1'b0);
    endtask

    task automatic test_overflow;
        rd_addr_phase(AW'($urandom));
        rd_ack(1);
        rd_capture(BL + 1);
        rd_drain(1'b0);
        // err_ovf stays set through a following clean read
        rd_addr_phase(AW'($urandom));
        rd_ack(0);
        rd_capture(BL);
        rd_drain(1'b1);
    endtask

    task automatic test_reset_midburst;
        wr_gather(BL, 1'b0);
        sdram_wr_ack = 1'b1;
        tick;
        sdram_wr_ack = 1'b0;
        sdram_wr_data_valid = 1'b1;
        tick;
        test_reset;
        wr_gather(BL, 1'b1);
        wr_burst(1);
        rd_addr_phase(AW'($urandom));
        rd_ack(0);
        rd_capture(BL);
        rd_ready = 1'b1;
        tick;
        test_reset;
        rd_addr_phase(AW'($urandom));
        rd_ack(2);
        rd_capture(BL);
        rd_drain(1'b1);
    endtask

    initial begin
        #2;
        test_reset;
        test_full_write;
        test_short_write;
        test_random_writes;
        test_read_stall;
        test_random_reads;
        test_concurrent;
        test_overflow;
        test_reset_midburst;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
